rv_lsu_bus: RTL and testbench
=============================

# rv_lsu_bus

Parametrised load/store unit for the memory-access stage of the pipelined core. It replaces fixed-latency data-memory access with a request/acknowledge bus handshake of variable latency, and is generic in data-bus width (32 or 64 bits). It adds three behaviours: misaligned-access detection, bus-error and timeout reporting, and flush-safe draining of in-flight transactions. It sits between the execute-stage outputs and the writeback stage, and stalls the pipeline for the duration of every bus transaction.

## Interface
- DW, 32, data-bus width; legal values are 32 and 64.
- AW, 32, address width.
- TIMEOUT, 255, maximum cycles spent waiting for i_mem_ack before a bus error is flagged; minimum value 1.
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_ce  in  1  stage clock-enable; a request is valid only while i_ce is high.
- i_load  in  1  the current instruction is a load.
- i_store  in  1  the current instruction is a store.
- i_funct3  in  3  access size and sign: [1:0] is 00 byte, 01 half, 10 word, 11 double (legal only when DW=64); [2]=1 means zero-extend.
- i_addr  in  AW  effective address.
- i_rs2  in  DW  store data.
- i_flush  in  1  discard the current or pending access.
- o_stall  out  1  pipeline stall request.
- o_done  out  1  one-cycle pulse when an access completes.
- o_data_load  out  DW  load result, sign- or zero-extended.
- o_misaligned  out  1  one-cycle pulse: misaligned or illegal-size access.
- o_bus_err  out  1  one-cycle pulse: i_mem_err or timeout.
- o_mem_req  out  1  bus request.
- o_mem_we  out  1  1 for a store.
- o_mem_addr  out  AW  address, aligned down to DW/8 bytes.
- o_mem_wdata  out  DW  store data shifted into its byte lanes.
- o_mem_mask  out  DW/8  byte-lane write mask (all zero for loads).
- i_mem_ack  in  1  transaction complete.
- i_mem_rdata  in  DW  read data; valid when i_mem_ack is high.
- i_mem_err  in  1  error qualifier; valid when i_mem_ack is high.

## Operation
- Definitions:
  - start = i_ce & (i_load|i_store) & !i_flush & state==IDLE.
  - lane = i_addr[log2(DW/8)-1:0].
  - size = 1 << i_funct3[1:0] bytes.
- Misaligned condition: lane is not a multiple of size, or i_funct3[1:0]==11 with DW=32.
- States:
  - IDLE, REQ, DRAIN.
- IDLE:
  - On start with the misaligned condition true: pulse o_misaligned and o_done next cycle, issue no bus request, remain in IDLE.
  - On start otherwise: latch address, mask, shifted data, funct3 and lane; go to REQ.
- Store encoding:
  - mask = ((1<<size)-1) << lane.
  - wdata = i_rs2 << (lane*8).
- REQ:
  - Hold o_mem_req=1. o_mem_addr, o_mem_we, o_mem_wdata and o_mem_mask stay constant until the ack.
  - On i_mem_ack: drop o_mem_req in the same edge, pulse o_done, and go to IDLE.
  - For loads on that ack: o_data_load = (i_mem_rdata >> lane*8), truncated to size and extended per i_funct3[2].
  - If i_mem_err is high with the ack: also pulse o_bus_err and leave o_data_load unchanged.
- Timeout counter:
  - Cleared on entry to REQ, incremented each REQ cycle without an ack.
  - On reaching TIMEOUT: drop o_mem_req, pulse o_bus_err and o_done, go to IDLE.
- i_flush while in REQ: go to DRAIN. Keep o_mem_req asserted until i_mem_ack or timeout, then go to IDLE with no o_done, no o_bus_err, and no o_data_load update.
- o_stall = start | (state==REQ) | (state==DRAIN), forced to 0 when i_flush is high in IDLE.
- Simultaneous i_load and i_store: treated as a store.

## Timing
- Reset: every output is 0, state is IDLE, and the counter is 0.
- Reset mid-transaction: o_mem_req drops asynchronously and the access is lost.
- Latency, with start at cycle 0:
  - o_mem_req rises in cycle 1.
  - If ack arrives in cycle N (N≥1), o_done and o_data_load are valid in cycle N+1.
  - Minimum latency is therefore 2 cycles.
- Misaligned access: o_misaligned and o_done are high in cycle 1; o_stall is high only in cycle 0.
- o_mem_req falls in cycle N+1. A new start is accepted in cycle N+1 at the earliest, i.e. there are no back-to-back requests without an idle cycle.
- An ack outside REQ or DRAIN is ignored.
- Timeout with TIMEOUT=T: o_bus_err pulses in cycle T+1 after o_mem_req first rises.
- o_done, o_misaligned and o_bus_err are single-cycle pulses.

## Test plan
- Setup: DW=32. Word load at addr 0x100, ack after 3 cycles with rdata 0xDEADBEEF. Required: o_mem_req high for 3 cycles, o_done once, o_data_load=0xDEADBEEF, o_stall low the cycle after o_done.
- Sign/zero extension: byte load at 0x103 with rdata 0x80xxxxxx gives 0xFFFFFF80 for funct3=000 and 0x00000080 for 100. Halfword store at 0x102 with rs2=0x1234 gives mask 1100 and wdata 0x12340000.
- Setup: DW=64. Doubleword load at 0x8 with rdata 0x0123456789ABCDEF. Required: o_data_load equals that value and mask is 0. Word store at 0xC drives mask 0xF0.
- Misaligned: word load at 0x102 and doubleword with DW=32. Required: o_misaligned and o_done in cycle 1, o_mem_req never asserted.
- Errors: ack with i_mem_err=1 pulses o_bus_err and leaves o_data_load unchanged. With TIMEOUT=4 and no ack, o_bus_err pulses and o_mem_req drops after 4 cycles.
- Flush in cycle 2 of a load with ack in cycle 5: o_mem_req stays high until the ack, with no o_done and no data update. The next load then completes normally.

Source files
------------

// File: rtl/rv_lsu_bus.sv
// rv_lsu_bus -- load/store unit for the memory-access stage.
//
// Converts an execute-stage load/store into a single request/acknowledge
// bus transaction of variable latency and stalls the pipeline until it
// finishes. Detects misaligned/illegal-size accesses, reports bus errors
// and timeouts, and drains an in-flight transaction silently on flush.
//
// Parameters:
//   DW       data-bus width, 32 or 64
//   AW       address width
//   TIMEOUT  max cycles waiting for i_mem_ack before a bus error (>= 1)
//
// Ports:
//   i_clk, i_rst_n       clock, async active-low reset
//   i_ce                 stage clock-enable (request valid only while high)
//   i_load, i_store      access type (both high -> store)
//   i_funct3             [1:0] size (B/H/W/D), [2] zero-extend
//   i_addr, i_rs2        effective address, store data
//   i_flush              discard current or pending access
//   o_stall              pipeline stall request
//   o_done               completion pulse
//   o_data_load          extended load result
//   o_misaligned         misaligned / illegal-size pulse
//   o_bus_err            bus error or timeout pulse
//   o_mem_*              bus request side (req, we, aligned addr, lane data, mask)
//   i_mem_ack/rdata/err  bus response side
module rv_lsu_bus #(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_ce,
    input  logic            i_load,
    input  logic            i_store,
    input  logic [2:0]      i_funct3,
    input  logic [AW-1:0]   i_addr,
    input  logic [DW-1:0]   i_rs2,
    input  logic            i_flush,
    output logic            o_stall,
    output logic            o_done,
    output logic [DW-1:0]   o_data_load,
    output logic            o_misaligned,
    output logic            o_bus_err,
    output logic            o_mem_req,
    output logic            o_mem_we,
    output logic [AW-1:0]   o_mem_addr,
    output logic [DW-1:0]   o_mem_wdata,
    output logic [DW/8-1:0] o_mem_mask,
    input  logic            i_mem_ack,
    input  logic [DW-1:0]   i_mem_rdata,
    input  logic            i_mem_err
);

    localparam int NB = DW / 8;
    localparam int LW = $clog2(NB);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2:0]      f3_q;
    logic [LW-1:0]   lane_q;

    logic            start;
    logic [LW-1:0]   lane;
    logic [2:0]      lane3;
    logic            mis_c;
    logic [7:0]      size_mask;
    logic [NB-1:0]   st_mask;
    logic [DW-1:0]   st_wdata;
    logic [DW-1:0]   rsh;
    logic [63:0]     r64;
    logic [63:0]     ext64;
    logic            sx;
    logic            tmo;

    assign start = i_ce & (i_load | i_store) & ~i_flush & (state == IDLE);
    assign lane  = i_addr[LW-1:0];
    // Zero-extend lane to a fixed 3 bits so the alignment checks below
    // are written once for both bus widths.
    assign lane3 = 3'(lane);

    always_comb begin
        mis_c = 1'b0;
        case (i_funct3[1:0])
            2'b00:   mis_c = 1'b0;
            2'b01:   mis_c = lane3[0];
            2'b10:   mis_c = |lane3[1:0];
            default: mis_c = (DW == 32) || (|lane3);
        endcase
    end

    always_comb begin
        size_mask = 8'h01;
        case (i_funct3[1:0])
            2'b00:   size_mask = 8'h01;
            2'b01:   size_mask = 8'h03;
            2'b10:   size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    end

    assign st_mask  = NB'(size_mask) << lane;
    assign st_wdata = i_rs2 << {lane, 3'b000};

    // Load path: shift the addressed lane down to bit 0, then truncate and
    // extend in a fixed 64-bit space so no zero-width replications appear
    // when DW is 32.
    assign rsh = i_mem_rdata >> {lane_q, 3'b000};
    assign r64 = 64'(rsh);
    assign sx  = ~f3_q[2];

    always_comb begin
        ext64 = r64;
        case (f3_q[1:0])
            2'b00:   ext64 = {{56{sx & r64[7]}},  r64[7:0]};
            2'b01:   ext64 = {{48{sx & r64[15]}}, r64[15:0]};
            2'b10:   ext64 = {{32{sx & r64[31]}}, r64[31:0]};
            default: ext64 = r64;
        endcase
    end

    assign tmo = (cnt == CW'(TIMEOUT - 1));

    // A pending request or drain always stalls; start already excludes flush.
    assign o_stall = start | (state != IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            f3_q         <= '0;
            lane_q       <= '0;
            o_done       <= 1'b0;
            o_misaligned <= 1'b0;
            o_bus_err    <= 1'b0;
            o_data_load  <= '0;
            o_mem_req    <= 1'b0;
            o_mem_we     <= 1'b0;
            o_mem_addr   <= '0;
            o_mem_wdata  <= '0;
            o_mem_mask   <= '0;
        end else begin
            o_done       <= 1'b0;
            o_misaligned <= 1'b0;
            o_bus_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (mis_c) begin
                            o_misaligned <= 1'b1;
                            o_done       <= 1'b1;
                        end else begin
                            state       <= REQ;
                            cnt         <= '0;
                            f3_q        <= i_funct3;
                            lane_q      <= lane;
                            o_mem_req   <= 1'b1;
                            o_mem_we    <= i_store;
                            o_mem_addr  <= {i_addr[AW-1:LW], {LW{1'b0}}};
                            o_mem_wdata <= st_wdata;
                            o_mem_mask  <= i_store ? st_mask : '0;
                        end
                    end
                end
                REQ: begin
                    if (i_mem_ack || tmo) begin
                        o_mem_req <= 1'b0;
                        state     <= IDLE;
                        // A flush coinciding with completion still discards it.
                        if (!i_flush) begin
                            o_done <= 1'b1;
                            if (!i_mem_ack || i_mem_err)
                                o_bus_err <= 1'b1;
                            else if (!o_mem_we)
                                o_data_load <= DW'(ext64);
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (i_flush)
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Finish the bus transaction but report nothing.
                    if (i_mem_ack || tmo) begin
                        o_mem_req <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    o_mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv_lsu_bus.sv
// Directed bench for rv_lsu_bus: one DW=32/TIMEOUT=4 instance and one
// DW=64/TIMEOUT=8 instance share the stimulus; 'sel' picks the active one.
module tb_rv_lsu_bus;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        ce = 1'b0, load = 1'b0, store = 1'b0, flush = 1'b0;
    logic [2:0]  f3 = '0;
    logic [31:0] addr = '0;
    logic [63:0] rs2 = '0;
    logic        ack = 1'b0, err = 1'b0;
    logic [63:0] rdata = '0;

    always #5 clk = ~clk;

    logic        s32, d32, m32, b32, q32, w32;
    logic [31:0] dl32, a32, wd32;
    logic [3:0]  k32;
    logic        s64, d64, m64, b64, q64, w64;
    logic [63:0] dl64, wd64;
    logic [31:0] a64;
    logic [7:0]  k64;

    rv_lsu_bus #(.DW(32), .AW(32), .TIMEOUT(4)) u32 (
        .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce & ~sel), .i_load(load),
        .i_store(store), .i_funct3(f3), .i_addr(addr), .i_rs2(rs2[31:0]),
        .i_flush(flush & ~sel), .o_stall(s32), .o_done(d32),
        .o_data_load(dl32), .o_misaligned(m32), .o_bus_err(b32),
        .o_mem_req(q32), .o_mem_we(w32), .o_mem_addr(a32),
        .o_mem_wdata(wd32), .o_mem_mask(k32), .i_mem_ack(ack & ~sel),
        .i_mem_rdata(rdata[31:0]), .i_mem_err(err)
    );

    rv_lsu_bus #(.DW(64), .AW(32), .TIMEOUT(8)) u64 (
        .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce & sel), .i_load(load),
        .i_store(store), .i_funct3(f3), .i_addr(addr), .i_rs2(rs2),
        .i_flush(flush & sel), .o_stall(s64), .o_done(d64),
        .o_data_load(dl64), .o_misaligned(m64), .o_bus_err(b64),
        .o_mem_req(q64), .o_mem_we(w64), .o_mem_addr(a64),
        .o_mem_wdata(wd64), .o_mem_mask(k64), .i_mem_ack(ack & sel),
        .i_mem_rdata(rdata), .i_mem_err(err)
    );

    logic        o_stall, o_done, o_mis, o_berr, o_req, o_we;
    logic [63:0] o_data, o_wdata;
    logic [31:0] o_addr;
    logic [7:0]  o_mask;

    always_comb begin
        o_stall = sel ? s64 : s32;
        o_done  = sel ? d64 : d32;
        o_mis   = sel ? m64 : m32;
        o_berr  = sel ? b64 : b32;
        o_req   = sel ? q64 : q32;
        o_we    = sel ? w64 : w32;
        o_data  = sel ? dl64 : {32'h0, dl32};
        o_wdata = sel ? wd64 : {32'h0, wd32};
        o_addr  = sel ? a64 : a32;
        o_mask  = sel ? k64 : {4'h0, k32};
    end

    typedef struct {
        int          req_cycles;
        int          done_cycle;   // 0: no o_done expected
        int          mis;
        int          berr;
        logic [63:0] data;
        logic [31:0] maddr;
        logic        we;
        logic [7:0]  mask;
        logic [63:0] wdata;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one access in cycle 0, then run 12 cycles with an optional ack
    // (cycle ackc) and flush (cycle flc), and score the observed behaviour.
    task automatic run(input string tag, input exp_t e, input logic ld, input logic st,
                       input logic [2:0] fn, input logic [31:0] a, input logic [63:0] d,
                       input int ackc, input logic [63:0] rd, input logic er, input int flc);
        int reqc, donec, donecyc, misc, errc, unstable, stall_after;
        logic first;
        logic [31:0] ca;
        logic cw;
        logic [7:0] cm;
        logic [63:0] cd;
        exp_t x;
        reqc = 0; donec = 0; donecyc = 0; misc = 0; errc = 0; unstable = 0;
        stall_after = 0; first = 1'b1; ca = '0; cw = 1'b0; cm = '0; cd = '0;
        @(posedge clk); #1;
        ce = 1'b1; load = ld; store = st; f3 = fn; addr = a; rs2 = d;
        ack = 1'b0; flush = 1'b0;
        sb.push_back(e);
        @(negedge clk);
        chk({tag, "_stall0"}, 64'(o_stall), 64'(1));
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            ce = 1'b0; load = 1'b0; store = 1'b0;
            ack = (c == ackc); rdata = rd; err = er & (c == ackc); flush = (c == flc);
            @(negedge clk);
            if (o_req) begin
                reqc++;
                if (first) begin
                    ca = o_addr; cw = o_we; cm = o_mask; cd = o_wdata; first = 1'b0;
                end else if (ca !== o_addr || cw !== o_we || cm !== o_mask || cd !== o_wdata) begin
                    unstable++;
                end
            end
            if (o_done) begin donec++; donecyc = c; end
            if (o_mis) misc++;
            if (o_berr) errc++;
            if (donecyc != 0 && c == donecyc + 1) stall_after = int'(o_stall);
        end
        ack = 1'b0; flush = 1'b0; err = 1'b0;
        x = sb.pop_front();
        chk({tag, "_req_cycles"}, 64'(reqc), 64'(x.req_cycles));
        chk({tag, "_done_count"}, 64'(donec), (x.done_cycle != 0) ? 64'(1) : 64'(0));
        chk({tag, "_done_cycle"}, 64'(donecyc), 64'(x.done_cycle));
        chk({tag, "_misaligned"}, 64'(misc), 64'(x.mis));
        chk({tag, "_bus_err"}, 64'(errc), 64'(x.berr));
        chk({tag, "_data"}, o_data, x.data);
        chk({tag, "_stall_after"}, 64'(stall_after), 64'(0));
        if (x.req_cycles > 0) begin
            chk({tag, "_unstable"}, 64'(unstable), 64'(0));
            chk({tag, "_addr"}, 64'(ca), 64'(x.maddr));
            chk({tag, "_we"}, 64'(cw), 64'(x.we));
            chk({tag, "_mask"}, 64'(cm), 64'(x.mask));
            chk({tag, "_wdata"}, cd, x.wdata);
        end
    endtask

    initial begin
        // Reset state of both instances
        rst_n = 1'b0;
        #12;
        chk("rst32_flags", 64'({s32, d32, m32, b32, q32, w32}), 64'(0));
        chk("rst32_vec", 64'({dl32, a32}), 64'(0));
        chk("rst32_wm", 64'({wd32, k32}), 64'(0));
        chk("rst64_flags", 64'({s64, d64, m64, b64, q64, w64}), 64'(0));
        chk("rst64_data", dl64, 64'(0));
        chk("rst64_wm", wd64 | 64'(k64) | 64'(a64), 64'(0));
        @(posedge clk); #1 rst_n = 1'b1;

        sel = 1'b0;
        //                        req done mis err data                  addr        we mask  wdata
        run("ld_word",   '{3, 4, 0, 0, 64'hDEADBEEF, 32'h100, 0, 8'h0, 64'h0},
            1, 0, 3'b010, 32'h100, 64'h0, 3, 64'hDEADBEEF, 0, 0);
        run("ld_byte_s", '{1, 2, 0, 0, 64'hFFFFFF80, 32'h100, 0, 8'h0, 64'h0},
            1, 0, 3'b000, 32'h103, 64'h0, 1, 64'h80123456, 0, 0);
        run("ld_byte_u", '{1, 2, 0, 0, 64'h00000080, 32'h100, 0, 8'h0, 64'h0},
            1, 0, 3'b100, 32'h103, 64'h0, 1, 64'h80123456, 0, 0);
        run("st_half",   '{2, 3, 0, 0, 64'h00000080, 32'h100, 1, 8'hC, 64'h12340000},
            0, 1, 3'b001, 32'h102, 64'h1234, 2, 64'h0, 0, 0);
        run("mis_word",  '{0, 1, 1, 0, 64'h00000080, 32'h0, 0, 8'h0, 64'h0},
            1, 0, 3'b010, 32'h102, 64'h0, 1, 64'h0, 0, 0);
        run("mis_dw32",  '{0, 1, 1, 0, 64'h00000080, 32'h0, 0, 8'h0, 64'h0},
            1, 0, 3'b011, 32'h0, 64'h0, 0, 64'h0, 0, 0);
        run("bus_err",   '{2, 3, 0, 1, 64'h00000080, 32'h200, 0, 8'h0, 64'h0},
            1, 0, 3'b010, 32'h200, 64'h0, 2, 64'h11111111, 1, 0);
        run("timeout",   '{4, 5, 0, 1, 64'h00000080, 32'h300, 0, 8'h0, 64'h0},
            1, 0, 3'b010, 32'h300, 64'h0, 0, 64'h0, 0, 0);
        run("ld_ls_st",  '{2, 3, 0, 0, 64'h00000080, 32'h100, 1, 8'h8, 64'h55000000},
            1, 1, 3'b000, 32'h103, 64'h55, 2, 64'h0, 0, 0);

        sel = 1'b1;
        run("ld_dword",  '{2, 3, 0, 0, 64'h0123456789ABCDEF, 32'h8, 0, 8'h00, 64'h0},
            1, 0, 3'b011, 32'h8, 64'h0, 2, 64'h0123456789ABCDEF, 0, 0);
        run("st_word64", '{1, 2, 0, 0, 64'h0123456789ABCDEF, 32'h8, 1, 8'hF0, 64'hCAFEF00D00000000},
            0, 1, 3'b010, 32'hC, 64'hCAFEF00D, 1, 64'h0, 0, 0);
        run("flush",     '{5, 0, 0, 0, 64'h0123456789ABCDEF, 32'h10, 0, 8'h00, 64'h0},
            1, 0, 3'b010, 32'h10, 64'h0, 5, 64'h5555, 0, 2);
        run("after_fl",  '{1, 2, 0, 0, 64'hFFFFFFFF89ABCDEF, 32'h10, 0, 8'h00, 64'h0},
            1, 0, 3'b010, 32'h14, 64'h0, 1, 64'h89ABCDEF00000000, 0, 0);

        // Asynchronous reset in the middle of a transaction
        sel = 1'b0;
        @(posedge clk); #1;
        ce = 1'b1; load = 1'b1; f3 = 3'b010; addr = 32'h400;
        @(posedge clk); #1;
        ce = 1'b0; load = 1'b0;
        @(negedge clk);
        chk("arst_req_before", 64'(o_req), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("arst_req_after", 64'(o_req), 64'(0));
        chk("arst_stall_after", 64'(o_stall), 64'(0));
        @(posedge clk); #1 rst_n = 1'b1;
        run("post_rst",  '{1, 2, 0, 0, 64'h12345678, 32'h500, 0, 8'h0, 64'h0},
            1, 0, 3'b010, 32'h500, 64'h0, 1, 64'h12345678, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
